// File: rtl/systolic_feeder_if.sv
// Upstream beat stream plus skewed array-side buses and tile status for the feeder.
interface systolic_feeder_if #(
  parameter int unsigned size = 4
);
  localparam int unsigned bus_w = 8 * size;
  localparam int unsigned cnt_w = $clog2(size) + 8;

  logic             s_valid;
  logic             s_ready;
  logic [bus_w-1:0] s_weight;
  logic [bus_w-1:0] s_in;
  logic             s_last;
  logic [bus_w-1:0] weight;
  logic [bus_w-1:0] in;
  logic             busy;
  logic             done;
  logic [cnt_w-1:0] beat_cnt;

  modport master (
    output s_valid, s_weight, s_in, s_last,
    input  s_ready, weight, in, busy, done, beat_cnt
  );

  modport slave (
    input  s_valid, s_weight, s_in, s_last,
    output s_ready, weight, in, busy, done, beat_cnt
  );
endinterface

// File: rtl/systolic_feeder.sv
// Systolic array feeder: accepts operand beats, skews lane k by k+1 cycles,
// then flushes the array for 2*size-1 cycles and pulses done per tile.
module systolic_feeder #(
  parameter int unsigned size = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  systolic_feeder_if.slave bus
);
  localparam int unsigned bus_w = 8 * size;
  localparam int unsigned cnt_w = $clog2(size) + 8;
  localparam int unsigned fl_w  = $clog2(2 * size);
  localparam logic [fl_w-1:0]  fl_init = fl_w'(2 * size - 1);
  localparam logic [cnt_w-1:0] cnt_max = '1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t           state_q, state_d;
  logic [fl_w-1:0]  fl_q, fl_d;
  logic             ready_q, busy_q, done_q;
  logic [cnt_w-1:0] cnt_q;
  logic             accept_c;
  logic [bus_w-1:0] inj_w_c, inj_i_c;
  logic [bus_w-1:0] lane_w, lane_i;

  // Beats only enter on a handshake; otherwise a zero bubble is injected.
  assign accept_c = bus.s_valid && ready_q;
  assign inj_w_c  = accept_c ? bus.s_weight : '0;
  assign inj_i_c  = accept_c ? bus.s_in : '0;

  // Next-state and flush-counter logic.
  always_comb begin
    state_d = state_q;
    fl_d    = fl_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (bus.s_last) begin
            state_d = FLUSH;
            fl_d    = fl_init;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept_c && bus.s_last) begin
          state_d = FLUSH;
          fl_d    = fl_init;
        end
      end
      FLUSH: begin
        fl_d = fl_q - 1'b1;
        if (fl_q == fl_w'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; handshake/status flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fl_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fl_q    <= fl_d;
      ready_q <= (state_d == IDLE) || (state_d == STREAM);
      busy_q  <= (state_d == STREAM) || (state_d == FLUSH);
      done_q  <= (state_d == DONE);
    end
  end

  // Accepted-beat counter: restarts at 1 on the first beat of a tile, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept_c) begin
      if (state_q == IDLE) cnt_q <= cnt_w'(1);
      else if (cnt_q != cnt_max) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Per-lane skew chains; lane k is k+1 bytes deep and never stalls.
  for (genvar k = 0; k < size; k++) begin : g_lane
    logic [8*(k+1)-1:0] w_sr, i_sr;

    if (k == 0) begin : g_head
      // Single-stage chain for lane 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          w_sr <= '0;
          i_sr <= '0;
        end else begin
          w_sr <= inj_w_c[7:0];
          i_sr <= inj_i_c[7:0];
        end
      end
    end else begin : g_tail
      // Shift newest byte in at the bottom; oldest byte drives the lane.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          w_sr <= '0;
          i_sr <= '0;
        end else begin
          w_sr <= {w_sr[8*k-1:0], inj_w_c[8*k +: 8]};
          i_sr <= {i_sr[8*k-1:0], inj_i_c[8*k +: 8]};
        end
      end
    end

    assign lane_w[8*k +: 8] = w_sr[8*k +: 8];
    assign lane_i[8*k +: 8] = i_sr[8*k +: 8];
  end

  assign bus.s_ready  = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.beat_cnt = cnt_q;
  assign bus.weight   = lane_w;
  assign bus.in       = lane_i;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed and scoreboarded checks for systolic_feeder at size=4.
module tb_systolic_feeder;
  localparam int unsigned size = 4;
  localparam int nrand = 10000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] slot_w [12000];
  logic [31:0] slot_i [12000];
  int          nslot;

  systolic_feeder_if #(.size(size)) bus ();
  systolic_feeder #(.size(size)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] wv, input logic [31:0] iv, input logic l);
    bus.s_valid  = v;
    bus.s_weight = wv;
    bus.s_in     = iv;
    bus.s_last   = l;
  endtask

  // Lane k in cycle c carries the vector injected in cycle c-k-1.
  function automatic logic [31:0] exp_vec(input bit sel_in, input int c);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      int s;
      s = c - k - 1;
      if (s >= 0 && s < nslot) r[8*k +: 8] = sel_in ? slot_i[s][8*k +: 8] : slot_w[s][8*k +: 8];
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, '0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", bus.s_ready); end
    checks++; if (bus.weight !== 32'h0) begin errors++; $display("FAIL reset_weight got %h want 0", bus.weight); end
    checks++; if (bus.in !== 32'h0) begin errors++; $display("FAIL reset_in got %h want 0", bus.in); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.done); end
    checks++; if (bus.beat_cnt !== 10'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.beat_cnt); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b want 1", bus.s_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %0b want 0", bus.busy); end
  endtask

  task automatic test_single_beat();
    slot_w[0] = 32'h04030201;
    slot_i[0] = 32'h80706050;
    nslot = 1;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin
        checks++; if (bus.weight !== exp_vec(0, c)) begin errors++; $display("FAIL single_weight c=%0d got %h want %h", c, bus.weight, exp_vec(0, c)); end
        checks++; if (bus.in !== exp_vec(1, c)) begin errors++; $display("FAIL single_in c=%0d got %h want %h", c, bus.in, exp_vec(1, c)); end
        checks++; if (bus.done !== (c == 8)) begin errors++; $display("FAIL single_done c=%0d got %0b", c, bus.done); end
        checks++; if (bus.s_ready !== (c >= 9)) begin errors++; $display("FAIL single_ready c=%0d got %0b", c, bus.s_ready); end
        checks++; if (bus.busy !== (c <= 7)) begin errors++; $display("FAIL single_busy c=%0d got %0b", c, bus.busy); end
      end
      if (c == 4) begin
        checks++; if (bus.weight !== 32'h04000000) begin errors++; $display("FAIL single_lane3 got %h want 04000000", bus.weight); end
      end
      if (c == 0) drive(1, slot_w[0], slot_i[0], 1);
      else drive(0, '0, '0, 0);
      tick();
    end
    checks++; if (bus.beat_cnt !== 10'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", bus.beat_cnt); end
  endtask

  task automatic test_back_to_back();
    int low;
    low = 0;
    slot_w[0] = 32'h0A0B0C0D; slot_i[0] = 32'hA0B0C0D0;
    slot_w[1] = 32'h1A1B1C1D; slot_i[1] = 32'hA1B1C1D1;
    slot_w[2] = 32'h2A2B2C2D; slot_i[2] = 32'hA2B2C2D2;
    slot_w[3] = 32'h3A3B3C3D; slot_i[3] = 32'hA3B3C3D3;
    nslot = 4;
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) begin
        if (bus.s_ready === 1'b0) low++;
        checks++; if (bus.weight !== exp_vec(0, c)) begin errors++; $display("FAIL b2b_weight c=%0d got %h want %h", c, bus.weight, exp_vec(0, c)); end
        checks++; if (bus.in !== exp_vec(1, c)) begin errors++; $display("FAIL b2b_in c=%0d got %h want %h", c, bus.in, exp_vec(1, c)); end
        checks++; if (bus.busy !== (c <= 10)) begin errors++; $display("FAIL b2b_busy c=%0d got %0b", c, bus.busy); end
        checks++; if (bus.done !== (c == 11)) begin errors++; $display("FAIL b2b_done c=%0d got %0b", c, bus.done); end
      end
      if (c == 4 || c == 11) begin
        checks++; if (bus.beat_cnt !== 10'd4) begin errors++; $display("FAIL b2b_cnt c=%0d got %0d want 4", c, bus.beat_cnt); end
      end
      if (c < 4) drive(1, slot_w[c], slot_i[c], c == 3);
      else drive(0, '0, '0, 0);
      tick();
    end
    checks++; if (low != 8) begin errors++; $display("FAIL b2b_ready_low got %0d cycles want 8", low); end
  endtask

  task automatic test_bubble();
    slot_w[0] = 32'h11223344; slot_i[0] = 32'h55667788;
    slot_w[1] = 32'h0;        slot_i[1] = 32'h0;
    slot_w[2] = 32'h99AABBCC; slot_i[2] = 32'hDDEEFF01;
    nslot = 3;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin
        checks++; if (bus.weight !== exp_vec(0, c)) begin errors++; $display("FAIL bubble_weight c=%0d got %h want %h", c, bus.weight, exp_vec(0, c)); end
        checks++; if (bus.in !== exp_vec(1, c)) begin errors++; $display("FAIL bubble_in c=%0d got %h want %h", c, bus.in, exp_vec(1, c)); end
        checks++; if (bus.busy !== (c <= 9)) begin errors++; $display("FAIL bubble_busy c=%0d got %0b", c, bus.busy); end
        checks++; if (bus.s_ready !== (c <= 2 || c >= 11)) begin errors++; $display("FAIL bubble_ready c=%0d got %0b", c, bus.s_ready); end
        checks++; if (bus.done !== (c == 10)) begin errors++; $display("FAIL bubble_done c=%0d got %0b", c, bus.done); end
      end
      if (c == 2) begin
        checks++; if (bus.beat_cnt !== 10'd1) begin errors++; $display("FAIL bubble_cnt_hold got %0d want 1", bus.beat_cnt); end
      end
      if (c == 3) begin
        checks++; if (bus.beat_cnt !== 10'd2) begin errors++; $display("FAIL bubble_cnt got %0d want 2", bus.beat_cnt); end
      end
      if (c == 0) drive(1, slot_w[0], slot_i[0], 0);
      else if (c == 2) drive(1, slot_w[2], slot_i[2], 1);
      else drive(0, '0, '0, 0);
      tick();
    end
  endtask

  task automatic test_continuous_valid();
    slot_w[0] = 32'hC1C2C3C4; slot_i[0] = 32'hD1D2D3D4;
    slot_w[1] = 32'hE1E2E3E4; slot_i[1] = 32'hF1F2F3F4;
    for (int s = 2; s < 10; s++) begin slot_w[s] = '0; slot_i[s] = '0; end
    slot_w[10] = 32'h71727374; slot_i[10] = 32'h81828384;
    nslot = 11;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) begin
        checks++; if (bus.weight !== exp_vec(0, c)) begin errors++; $display("FAIL cont_weight c=%0d got %h want %h", c, bus.weight, exp_vec(0, c)); end
        checks++; if (bus.in !== exp_vec(1, c)) begin errors++; $display("FAIL cont_in c=%0d got %h want %h", c, bus.in, exp_vec(1, c)); end
        checks++; if (bus.done !== (c == 9 || c == 18)) begin errors++; $display("FAIL cont_done c=%0d got %0b", c, bus.done); end
        checks++; if (bus.s_ready !== (c == 1 || c == 10 || c >= 19)) begin errors++; $display("FAIL cont_ready c=%0d got %0b", c, bus.s_ready); end
        checks++; if (bus.busy !== ((c <= 8) || (c >= 11 && c <= 17))) begin errors++; $display("FAIL cont_busy c=%0d got %0b", c, bus.busy); end
      end
      if (c == 10) begin
        checks++; if (bus.beat_cnt !== 10'd2) begin errors++; $display("FAIL cont_cnt_tile1 got %0d want 2", bus.beat_cnt); end
      end
      if (c == 11) begin
        checks++; if (bus.beat_cnt !== 10'd1) begin errors++; $display("FAIL cont_cnt_tile2 got %0d want 1", bus.beat_cnt); end
      end
      if (c == 0) drive(1, slot_w[0], slot_i[0], 0);
      else if (c == 1) drive(1, slot_w[1], slot_i[1], 1);
      else if (c <= 10) drive(1, slot_w[10], slot_i[10], 1);
      else drive(0, '0, '0, 0);
      tick();
    end
  endtask

  task automatic test_reset_flush();
    drive(1, 32'hDEADBEEF, 32'h55AA33CC, 1);
    tick();
    drive(0, '0, '0, 0);
    tick();
    tick();
    checks++; if (bus.weight !== 32'h00AD0000) begin errors++; $display("FAIL rstfl_pre_weight got %h want 00ad0000", bus.weight); end
    checks++; if (bus.in !== 32'h00AA0000) begin errors++; $display("FAIL rstfl_pre_in got %h want 00aa0000", bus.in); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.weight !== 32'h0) begin errors++; $display("FAIL rstfl_weight got %h want 0", bus.weight); end
    checks++; if (bus.in !== 32'h0) begin errors++; $display("FAIL rstfl_in got %h want 0", bus.in); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstfl_busy got %0b want 0", bus.busy); end
    checks++; if (bus.beat_cnt !== 10'd0) begin errors++; $display("FAIL rstfl_cnt got %0d want 0", bus.beat_cnt); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rstfl_ready_low got %0b want 0", bus.s_ready); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rstfl_ready got %0b want 1", bus.s_ready); end
    for (int c = 0; c < 12; c++) begin
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstfl_done c=%0d got %0b want 0", c, bus.done); end
      checks++; if (bus.weight !== 32'h0 || bus.in !== 32'h0) begin errors++; $display("FAIL rstfl_lanes c=%0d got %h/%h want 0", c, bus.weight, bus.in); end
      tick();
    end
  endtask

  task automatic test_saturate();
    for (int b = 0; b < 1030; b++) begin
      drive(1, '0, '0, 0);
      tick();
      if (b == 1021) begin
        checks++; if (bus.beat_cnt !== 10'd1022) begin errors++; $display("FAIL sat_below got %0d want 1022", bus.beat_cnt); end
      end
      if (b == 1022 || b == 1029) begin
        checks++; if (bus.beat_cnt !== 10'd1023) begin errors++; $display("FAIL sat_hold b=%0d got %0d want 1023", b, bus.beat_cnt); end
      end
    end
    drive(1, '0, '0, 1);
    tick();
    drive(0, '0, '0, 0);
    checks++; if (bus.beat_cnt !== 10'd1023) begin errors++; $display("FAIL sat_last got %0d want 1023", bus.beat_cnt); end
    repeat (8) tick();
    checks++; if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL sat_idle ready=%0b busy=%0b want 1/0", bus.s_ready, bus.busy); end
  endtask

  task automatic test_random();
    int m_st, m_fl, m_cnt;
    logic m_ready, v, l, acc;
    logic [31:0] dw, di;
    m_st = 0; m_fl = 0; m_cnt = 1023; m_ready = 1'b1;
    nslot = 0;
    for (int m = 0; m < nrand + 12; m++) begin
      checks++; if (bus.weight !== exp_vec(0, m)) begin errors++; $display("FAIL rand_weight m=%0d got %h want %h", m, bus.weight, exp_vec(0, m)); end
      checks++; if (bus.in !== exp_vec(1, m)) begin errors++; $display("FAIL rand_in m=%0d got %h want %h", m, bus.in, exp_vec(1, m)); end
      checks++; if (bus.s_ready !== m_ready) begin errors++; $display("FAIL rand_ready m=%0d got %0b want %0b", m, bus.s_ready, m_ready); end
      checks++; if (bus.done !== (m_st == 3)) begin errors++; $display("FAIL rand_done m=%0d got %0b", m, bus.done); end
      checks++; if (bus.busy !== (m_st == 1 || m_st == 2)) begin errors++; $display("FAIL rand_busy m=%0d got %0b", m, bus.busy); end
      checks++; if (bus.beat_cnt !== 10'(m_cnt)) begin errors++; $display("FAIL rand_cnt m=%0d got %0d want %0d", m, bus.beat_cnt, m_cnt); end
      v  = (m < nrand) && ($urandom_range(0, 9) < 7);
      l  = ($urandom_range(0, 3) == 0);
      dw = $urandom;
      di = $urandom;
      drive(v, dw, di, l);
      acc = v && m_ready;
      slot_w[m] = acc ? dw : 32'h0;
      slot_i[m] = acc ? di : 32'h0;
      nslot = m + 1;
      case (m_st)
        0: if (acc) begin
             m_cnt = 1;
             if (l) begin m_st = 2; m_fl = 7; end else m_st = 1;
           end
        1: if (acc) begin
             if (m_cnt < 1023) m_cnt++;
             if (l) begin m_st = 2; m_fl = 7; end
           end
        2: begin m_fl--; if (m_fl == 0) m_st = 3; end
        default: m_st = 0;
      endcase
      m_ready = (m_st <= 1);
      tick();
    end
    drive(0, '0, '0, 0);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_bubble();
    test_continuous_valid();
    test_reset_flush();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
